// File: rtl/life_pkg.sv
// Shared encodings for the life-array sequencer: FSM states, quadrant and
// preset indices, and the quadrant data width.
package life_pkg;

    localparam int QUAD_W = 16;

    // FSM state encoding; also driven out on state_dbg for the board LEDs.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    // Quadrant indices as seen by the array's vali_selector input.
    localparam logic [1:0] QUAD_NW = 2'd0;
    localparam logic [1:0] QUAD_NE = 2'd1;
    localparam logic [1:0] QUAD_SW = 2'd2;
    localparam logic [1:0] QUAD_SE = 2'd3;

    // Preset pattern indices selected by pattern_sel.
    localparam logic [1:0] PAT_CLEAR   = 2'd0;
    localparam logic [1:0] PAT_GLIDER  = 2'd1;
    localparam logic [1:0] PAT_BLINKER = 2'd2;
    localparam logic [1:0] PAT_FULL    = 2'd3;

    // Non-trivial quadrant contents; bit[4*r+c] is row r, column c.
    localparam logic [QUAD_W-1:0] GLIDER_NW  = 16'h0742;
    localparam logic [QUAD_W-1:0] BLINKER_NW = 16'h0070;

endpackage

// File: rtl/life_pattern_rom.sv
// Preset pattern ROM: maps {pattern, quadrant} to the 16-bit quadrant image.
// Purely combinational; the sequencer registers the result.
module life_pattern_rom
    import life_pkg::*;
(
    input  logic [1:0]        pattern,
    input  logic [1:0]        quad,
    output logic [QUAD_W-1:0] data
);

    // Decode preset and quadrant into the stored image; unlisted quadrants are empty.
    always_comb begin
        data = '0;
        case (pattern)
            PAT_CLEAR: begin
                data = '0;
            end
            PAT_GLIDER: begin
                if (quad == QUAD_NW) data = GLIDER_NW;
            end
            PAT_BLINKER: begin
                if (quad == QUAD_NW) data = BLINKER_NW;
            end
            PAT_FULL: begin
                data = '1;
            end
            default: begin
                data = '0;
            end
        endcase
    end

endmodule

// File: rtl/life_sequencer.sv
// Life array sequencer: loads preset patterns quadrant by quadrant and
// issues generation steps, each one aligned to a VGA frame pulse so the
// array only changes during vertical blank.
//
// Handshake: there is no valid/ready pair here. load_req, single_step and
// frame are single-cycle pulses sampled on the rising edge; load_req is
// honoured only in IDLE, step requests collapse into one pending flag, and
// write_enb/step are single-cycle strobes to the array with no backpressure.
//
// Every output is a register loaded from next-state values, so outputs line
// up with the state they describe and no input reaches an output
// combinationally.
module life_sequencer
    import life_pkg::*;
#(
    parameter int STEP_DIV = 100000000,
    parameter int GEN_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_en,
    input  logic              single_step,
    input  logic              load_req,
    input  logic [1:0]        pattern_sel,
    input  logic              frame,
    output logic [QUAD_W-1:0] vali,
    output logic [1:0]        vali_selector,
    output logic              write_enb,
    output logic              step,
    output logic              busy,
    output logic              step_pending,
    output logic [GEN_W-1:0]  generation,
    output logic [1:0]        state_dbg
);

    localparam int              CNT_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         quad;
    logic [1:0]         quad_nxt;
    logic [1:0]         pat;
    logic [1:0]         pat_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               tick;
    logic               load_accept;
    logic               pending_nxt;
    logic [GEN_W-1:0]   gen_nxt;
    logic [QUAD_W-1:0]  rom_data;

    // The ROM is addressed with the next pattern/quadrant so its data can be
    // registered alongside the write strobe it belongs to.
    life_pattern_rom u_rom (
        .pattern (pat_nxt),
        .quad    (quad_nxt),
        .data    (rom_data)
    );

    // Automatic step tick: one pulse every STEP_DIV cycles of run_en.
    always_comb begin
        tick = run_en && (cnt == CNT_LAST);
    end

    // Tick counter next value: dropping run_en or taking a load restarts the period.
    always_comb begin
        cnt_nxt = cnt + 1'b1;
        if (!run_en || load_accept) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
        end
    end

    // FSM next state, load quadrant walk, pending flag and generation count.
    always_comb begin
        state_nxt   = state;
        quad_nxt    = quad;
        pat_nxt     = pat;
        load_accept = 1'b0;
        pending_nxt = step_pending;
        gen_nxt     = generation;
        case (state)
            ST_IDLE: begin
                if (load_req) begin
                    state_nxt   = ST_LOAD;
                    quad_nxt    = QUAD_NW;
                    pat_nxt     = pattern_sel;
                    load_accept = 1'b1;
                    pending_nxt = 1'b0;
                    gen_nxt     = '0;
                end else if (step_pending && frame) begin
                    // Pending stays set through the STEP cycle and is cleared
                    // on the way out, so a request arriving then is dropped.
                    state_nxt = ST_STEP;
                    gen_nxt   = generation + 1'b1;
                end else begin
                    pending_nxt = step_pending | tick | single_step;
                end
            end
            ST_LOAD: begin
                pending_nxt = 1'b0;
                if (quad == QUAD_SE) begin
                    state_nxt = ST_IDLE;
                end else begin
                    quad_nxt = quad + 2'd1;
                end
            end
            ST_STEP: begin
                pending_nxt = 1'b0;
                state_nxt   = ST_IDLE;
            end
            default: begin
                pending_nxt = 1'b0;
                state_nxt   = ST_IDLE;
            end
        endcase
    end

    // Internal state registers: FSM, load cursor, latched preset, tick counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            quad  <= QUAD_NW;
            pat   <= PAT_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            quad  <= quad_nxt;
            pat   <= pat_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs derived from the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_enb     <= 1'b0;
            vali_selector <= '0;
            vali          <= '0;
            step          <= 1'b0;
            busy          <= 1'b0;
            step_pending  <= 1'b0;
            generation    <= '0;
            state_dbg     <= ST_IDLE;
        end else begin
            write_enb     <= (state_nxt == ST_LOAD);
            vali_selector <= (state_nxt == ST_LOAD) ? quad_nxt : 2'd0;
            vali          <= (state_nxt == ST_LOAD) ? rom_data : '0;
            step          <= (state_nxt == ST_STEP);
            busy          <= (state_nxt != ST_IDLE);
            step_pending  <= pending_nxt;
            generation    <= gen_nxt;
            state_dbg     <= state_nxt;
        end
    end

endmodule
